// File: rtl/msx_bus_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// msx_bus_pkg
// Shared definitions for the MSX cartridge-slot bus cycle controller:
//   bus_state_t    - controller FSM state encoding
//   OPEN_BUS       - value presented on the data bus when nothing drives it
//   DEFAULT_ADDR_W - default width of the slot address bus
// ---------------------------------------------------------------------------
package msx_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_REQ     = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_t;

    localparam logic [7:0] OPEN_BUS       = 8'hFF;
    localparam int         DEFAULT_ADDR_W = 16;

endpackage

// File: rtl/msx_bus_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// msx_bus_cycle_ctrl_if
// Bundles the filtered MSX edge-connector pins and the internal
// request/ack handshake of the bus cycle controller.
//   master : the controller (samples pins, drives bus data / wait / request)
//   slave  : the environment (pin filter bank outputs, internal responder)
// Signals:
//   sltsl_n, iorq_n, rd_n, wr_n, addr, bus_din   filtered bus inputs
//   bus_dout, bus_doe, wait_n                     bus-side outputs
//   req, req_wr, req_io, req_addr, req_wdata      request towards internal side
//   ack, rdata                                    completion from internal side
//   err                                           timeout / illegal strobe pulse
// ---------------------------------------------------------------------------
interface msx_bus_cycle_ctrl_if
    import msx_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              sltsl_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        bus_din;
    logic [7:0]        bus_dout;
    logic              bus_doe;
    logic              wait_n;
    logic              req;
    logic              req_wr;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              ack;
    logic [7:0]        rdata;
    logic              err;

    modport master (
        input  sltsl_n, iorq_n, rd_n, wr_n, addr, bus_din, ack, rdata,
        output bus_dout, bus_doe, wait_n, req, req_wr, req_io, req_addr,
               req_wdata, err
    );

    modport slave (
        output sltsl_n, iorq_n, rd_n, wr_n, addr, bus_din, ack, rdata,
        input  bus_dout, bus_doe, wait_n, req, req_wr, req_io, req_addr,
               req_wdata, err
    );

endinterface

// File: rtl/msx_bus_cycle_ctrl_sample_prescaler.sv
// ---------------------------------------------------------------------------
// sample_prescaler
// Generates the one-clk sample strobe for the GPIO pin filter bank.
// The counter runs 0..PRESCALE-1 and wraps; filt_ena is high for the clk
// in which the count equals PRESCALE-1. With PRESCALE=1 the strobe is
// permanently high once reset is released.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   filt_ena  registered sample strobe
// ---------------------------------------------------------------------------
module sample_prescaler #(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic filt_ena
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // filt_ena is registered from the next count so it lines up with cnt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            filt_ena <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            filt_ena <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/msx_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// msx_bus_cycle_ctrl
// Sequences MSX cartridge-slot memory and I/O cycles into single held
// requests on the internal request/ack interface, drives read data back
// onto the bus, and recovers from a missing ack with a timeout.
//
// Optional feature (macro MSX_WAIT_STRETCH_EN):
//   defined   - wait_n is pulled low in LATCH and REQ so the Z80 is stretched
//               until ack or timeout.
//   undefined - wait_n stays high; ack must land inside the native strobe.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   filt_ena  sample strobe to the pin filter bank
//   bus       msx_bus_cycle_ctrl_if.master (pins, request/ack, err)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a selected cycle with exactly one strobe
// ST_LATCH   | one clk: capture address/data/direction, clear timeout
// ST_REQ     | req held until ack or timeout
// ST_DRIVE   | read data driven onto the bus until rd_n rises or deselect
// ST_RELEASE | bus released, waiting for both strobes high
// ---------------------------------------------------------------------------
module msx_bus_cycle_ctrl
    import msx_bus_pkg::*;
#(
    parameter int PRESCALE    = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                filt_ena,
    msx_bus_cycle_ctrl_if.master bus
);

`ifdef MSX_WAIT_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    bus_state_t        state;
    logic [TW-1:0]     to_cnt;
    logic              req_q;
    logic              req_wr_q;
    logic              req_io_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        req_wdata_q;
    logic [7:0]        bus_dout_q;
    logic              bus_doe_q;
    logic              wait_q;
    logic              err_q;
    logic              aborted;
    logic              illegal_seen;

    logic sel;
    logic rd;
    logic wr;
    logic strobe;
    logic both_strobes;
    logic abort_now;
    logic go_drive;

    assign sel          = ~bus.sltsl_n | ~bus.iorq_n;
    assign rd           = ~bus.rd_n;
    assign wr           = ~bus.wr_n;
    assign strobe       = rd | wr;
    assign both_strobes = rd & wr;

    // A strobe released on the completion clk itself also counts as abort.
    assign abort_now = aborted | ~strobe;
    assign go_drive  = ~req_wr_q & ~abort_now;

    sample_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .filt_ena (filt_ena)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            to_cnt       <= '0;
            req_q        <= 1'b0;
            req_wr_q     <= 1'b0;
            req_io_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= 8'h00;
            bus_dout_q   <= OPEN_BUS;
            bus_doe_q    <= 1'b0;
            wait_q       <= 1'b1;
            err_q        <= 1'b0;
            aborted      <= 1'b0;
            illegal_seen <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel && both_strobes) begin
                        // One err pulse per illegal episode, not one per clk.
                        if (!illegal_seen) begin
                            err_q <= 1'b1;
                        end
                        illegal_seen <= 1'b1;
                    end else begin
                        illegal_seen <= 1'b0;
                        if (sel && strobe) begin
                            state  <= ST_LATCH;
                            wait_q <= ~STRETCH;
                        end
                    end
                end

                ST_LATCH: begin
                    req_addr_q  <= bus.addr;
                    req_wdata_q <= bus.bus_din;
                    req_wr_q    <= wr;
                    req_io_q    <= ~bus.iorq_n;
                    to_cnt      <= '0;
                    aborted     <= 1'b0;
                    req_q       <= 1'b1;
                    state       <= ST_REQ;
                end

                ST_REQ: begin
                    if (!strobe) begin
                        aborted <= 1'b1;
                    end
                    if (bus.ack || (to_cnt == TO_LAST)) begin
                        req_q     <= 1'b0;
                        wait_q    <= 1'b1;
                        bus_doe_q <= go_drive;
                        state     <= go_drive ? ST_DRIVE : ST_RELEASE;
                        if (bus.ack) begin
                            if (!req_wr_q) begin
                                bus_dout_q <= bus.rdata;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            bus_dout_q <= OPEN_BUS;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                ST_DRIVE: begin
                    if (bus.rd_n || !sel) begin
                        bus_doe_q <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (bus.rd_n && bus.wr_n) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req       = req_q;
    assign bus.req_wr    = req_wr_q;
    assign bus.req_io    = req_io_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.bus_dout  = bus_dout_q;
    assign bus.bus_doe   = bus_doe_q;
    assign bus.wait_n    = wait_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_msx_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msx_bus_cycle_ctrl
// Self-checking bench for msx_bus_cycle_ctrl (PRESCALE=4, TIMEOUT_CYC=8)
// plus a second instance with PRESCALE=1 for the constant-strobe case.
// Honours MSX_WAIT_STRETCH_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_msx_bus_cycle_ctrl;

    localparam int TO = 8;
`ifdef MSX_WAIT_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic filt4;
    logic filt1;

    int n_cmp = 0;
    int n_bad = 0;
    int err_total = 0;
    int edges_since_rst = 0;
    logic [7:0] exp_dout;

    always #5 clk = ~clk;

    msx_bus_cycle_ctrl_if #(.ADDR_W(16)) bif ();
    msx_bus_cycle_ctrl_if #(.ADDR_W(16)) bif1 ();

    msx_bus_cycle_ctrl #(
        .PRESCALE    (4),
        .TIMEOUT_CYC (TO),
        .ADDR_W      (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .filt_ena (filt4),
        .bus      (bif)
    );

    msx_bus_cycle_ctrl #(
        .PRESCALE    (1),
        .TIMEOUT_CYC (TO),
        .ADDR_W      (16)
    ) dut_p1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .filt_ena (filt1),
        .bus      (bif1)
    );

    initial begin
        bif1.sltsl_n = 1'b1;
        bif1.iorq_n  = 1'b1;
        bif1.rd_n    = 1'b1;
        bif1.wr_n    = 1'b1;
        bif1.addr    = 16'h0000;
        bif1.bus_din = 8'h00;
        bif1.ack     = 1'b0;
        bif1.rdata   = 8'h00;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Strobe model: filt_ena high on every clk where edges-since-reset mod 4 == 3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges_since_rst <= 0;
        else          edges_since_rst <= edges_since_rst + 1;
    end

    always @(negedge clk) begin
        if (bif.err === 1'b1) err_total++;
        if (reset_n === 1'b1) begin
            check_val("filt4", filt4, ((edges_since_rst % 4) == 3) ? 1 : 0);
            if (edges_since_rst > 0) check_val("filt1", filt1, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pins();
        bif.sltsl_n = 1'b1;
        bif.iorq_n  = 1'b1;
        bif.rd_n    = 1'b1;
        bif.wr_n    = 1'b1;
        bif.ack     = 1'b0;
    endtask

    // One bus cycle. k = REQ clk on which ack is presented (k > TO: no ack),
    // abort_at = REQ clk before which both strobes are released (0: never).
    task automatic run_cycle(input bit is_io, input bit both_sel, input bit is_wr,
                             input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] rv, input int k,
                             input int abort_at, input int hold);
        int  e;
        int  req_hi;
        int  err0;
        bit  tmo;
        bit  abrt;
        bit  drive;
        tmo   = (k > TO);
        e     = tmo ? TO : k;
        abrt  = (abort_at >= 1) && (abort_at <= e);
        drive = !is_wr && !abrt;
        err0  = err_total;

        if (is_io || both_sel) bif.iorq_n = 1'b0;
        if (!is_io || both_sel) bif.sltsl_n = 1'b0;
        bif.addr    = a;
        bif.bus_din = d;
        if (is_wr) bif.wr_n = 1'b0;
        else       bif.rd_n = 1'b0;

        tick();
        check_val("latch_req", bif.req, 0);
        check_val("latch_wait", bif.wait_n, !STRETCH);
        tick();
        check_val("req_on", bif.req, 1);
        check_val("req_wr", bif.req_wr, is_wr);
        check_val("req_io", bif.req_io, (is_io || both_sel));
        check_val("req_addr", bif.req_addr, a);
        if (is_wr) check_val("req_wdata", bif.req_wdata, d);
        req_hi = 1;
        for (int c = 1; c <= TO + 4; c++) begin
            if (c == abort_at) begin
                bif.rd_n = 1'b1;
                bif.wr_n = 1'b1;
            end
            bif.ack   = (c == k);
            bif.rdata = (c == k) ? rv : 8'($urandom);
            tick();
            bif.ack = 1'b0;
            if (bif.req !== 1'b1) break;
            req_hi++;
            check_val("req_wait", bif.wait_n, !STRETCH);
        end
        check_val("req_len", req_hi, e);
        if (tmo)         exp_dout = 8'hFF;
        else if (!is_wr) exp_dout = rv;
        check_val("done_dout", bif.bus_dout, exp_dout);
        check_val("done_doe", bif.bus_doe, drive);
        check_val("done_wait", bif.wait_n, 1);

        if (drive) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check_val("drv_doe", bif.bus_doe, 1);
                check_val("drv_dout", bif.bus_dout, exp_dout);
            end
            bif.rd_n = 1'b1;
        end else begin
            tick();
            check_val("rel_doe", bif.bus_doe, 0);
            bif.rd_n = 1'b1;
            bif.wr_n = 1'b1;
        end
        tick();
        check_val("post_doe", bif.bus_doe, 0);
        tick();
        idle_pins();
        tick();
        tick();
        check_val("post_req", bif.req, 0);
        check_val("post_dout", bif.bus_dout, exp_dout);
        check_val("err_cnt", err_total - err0, tmo ? 1 : 0);
    endtask

    task automatic reset_test(input bit in_drive);
        bif.sltsl_n = 1'b0;
        bif.addr    = 16'($urandom);
        bif.rd_n    = 1'b0;
        tick();
        tick();
        tick();
        check_val("rst_pre_req", bif.req, 1);
        if (in_drive) begin
            bif.ack   = 1'b1;
            bif.rdata = 8'h5A;
            tick();
            bif.ack = 1'b0;
            check_val("rst_pre_doe", bif.bus_doe, 1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_req", bif.req, 0);
        check_val("rst_doe", bif.bus_doe, 0);
        check_val("rst_wait", bif.wait_n, 1);
        check_val("rst_dout", bif.bus_dout, 8'hFF);
        exp_dout = 8'hFF;
        idle_pins();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int err0;
        reset_n     = 1'b0;
        idle_pins();
        bif.addr    = 16'h0000;
        bif.bus_din = 8'h00;
        bif.rdata   = 8'h00;
        exp_dout    = 8'hFF;
        #12;
        check_val("rst_req", bif.req, 0);
        check_val("rst_req_wr", bif.req_wr, 0);
        check_val("rst_req_io", bif.req_io, 0);
        check_val("rst_req_addr", bif.req_addr, 0);
        check_val("rst_req_wdata", bif.req_wdata, 0);
        check_val("rst_doe", bif.bus_doe, 0);
        check_val("rst_dout", bif.bus_dout, 8'hFF);
        check_val("rst_wait", bif.wait_n, 1);
        check_val("rst_err", bif.err, 0);
        check_val("rst_filt4", filt4, 0);
        check_val("rst_filt1", filt1, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) tick();

        // Memory read, ack on 3rd REQ clk.
        run_cycle(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 3, 0, 2);
        // I/O write.
        run_cycle(1'b1, 1'b0, 1'b1, 16'h0098, 8'h3C, 8'h00, 2, 0, 1);
        // Read with no ack -> timeout.
        run_cycle(1'b0, 1'b0, 1'b0, 16'h8123, 8'h00, 8'h77, TO + 3, 0, 2);
        // Ack on the terminal-count clk wins over timeout.
        run_cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hC3, TO, 0, 1);
        // Write with no ack.
        run_cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h99, 8'h00, TO + 1, 0, 1);
        // Aborted read: strobe gone before ack, no drive.
        run_cycle(1'b0, 1'b0, 1'b0, 16'h2222, 8'h00, 8'h11, 4, 2, 1);

        // Both strobes low with slot selected.
        err0 = err_total;
        bif.sltsl_n = 1'b0;
        bif.rd_n    = 1'b0;
        bif.wr_n    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("ill_req", bif.req, 0);
        end
        bif.rd_n = 1'b1;
        bif.wr_n = 1'b1;
        tick();
        idle_pins();
        tick();
        tick();
        check_val("ill_req_end", bif.req, 0);
        check_val("ill_err", err_total - err0, 1);

        reset_test(1'b0);
        reset_test(1'b1);

        // Randomised cycles with stray acks between them.
        for (int n = 0; n < 40; n++) begin
            int k;
            int ab;
            k  = int'($urandom_range(1, TO + 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO)) : 0;
            run_cycle(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                      8'($urandom), 8'($urandom), k, ab,
                      int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) begin
                err0 = err_total;
                bif.ack   = 1'b1;
                bif.rdata = 8'($urandom);
                tick();
                bif.ack = 1'b0;
                tick();
                check_val("stray_req", bif.req, 0);
                check_val("stray_doe", bif.bus_doe, 0);
                check_val("stray_dout", bif.bus_dout, exp_dout);
                check_val("stray_err", err_total - err0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msx_bus_cycle_ctrl.md
Name: msx_bus_cycle_ctrl

Overview:
Sequences cartridge-slot bus cycles between the debounced MSX edge-connector pins and the internal request/ack domain. It generates the sample-enable strobe for the GPIO filter bank. It detects slot memory and I/O read/write cycles and latches address and data. It issues a single held request per bus cycle, drives read data back onto the bus, and recovers from a missing ack by timing out.

Parameters:
PRESCALE, 2, clk cycles per filt_ena strobe (1 = strobe every clk)
TIMEOUT_CYC, 64, clk cycles in REQ with no ack before timeout
ADDR_W, 16, bus address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
filt_ena  out  1  one-clk sample strobe to the pin filter bank
sltsl_n  in  1  filtered slot select
iorq_n  in  1  filtered I/O request
rd_n  in  1  filtered read strobe
wr_n  in  1  filtered write strobe
addr  in  ADDR_W  filtered bus address
bus_din  in  8  filtered bus data
bus_dout  out  8  data driven onto bus on reads
bus_doe  out  1  bus data output enable
wait_n  out  1  MSX /WAIT (active low)
req  out  1  request to internal domain
req_wr  out  1  1 = write, 0 = read (valid while req)
req_io  out  1  1 = I/O cycle, 0 = slot memory (valid while req)
req_addr  out  ADDR_W  latched address (valid while req)
req_wdata  out  8  latched write data (valid while req)
ack  in  1  internal completion, sampled only while req=1
rdata  in  8  read data, valid on the ack cycle
err  out  1  one-clk pulse: timeout or illegal strobe combination

Behaviour:
- Reset is asynchronous and active-low; the clock is clk. On reset: state IDLE, prescaler 0, filt_ena=0, req=0, req_wr=0, req_io=0, req_addr=0, req_wdata=0, bus_doe=0, bus_dout=8'hFF, wait_n=1, err=0. Reset asserted mid-cycle aborts immediately. req is dropped with no ack required.
- Prescaler counts 0..PRESCALE-1 and wraps. filt_ena=1 for one clk when count==PRESCALE-1. With PRESCALE=1, filt_ena is constantly 1 after reset.
- Cycle start: sel = ~sltsl_n | ~iorq_n; strobe = ~rd_n | ~wr_n. The FSM evaluates every clk, not gated by filt_ena.
- IDLE: if sel & strobe & ~(~rd_n & ~wr_n), go to LATCH. If rd_n and wr_n are both low with sel, pulse err and stay in IDLE until one strobe releases.
- LATCH (1 clk): capture req_addr, req_wdata, req_wr=~wr_n, and req_io=~iorq_n (iorq takes priority if both selects are low). Clear the timeout counter. Go to REQ.
- REQ: req=1 with all payload stable. On a clk with ack=1, capture rdata into bus_dout (reads only), drop req the next clk, and go to DRIVE (read) or RELEASE (write).
- Latency: strobe first seen in IDLE at clk N, req=1 from clk N+2, bus_doe=1 from the clk after the ack clk.
- Timeout: the counter increments each clk in REQ. If it reaches TIMEOUT_CYC-1 without ack: pulse err, load bus_dout=8'hFF, drop req, and go to DRIVE (read) or RELEASE (write). If ack arrives on the same clk as the terminal count, ack wins and no err is raised.
- Strobe released while in REQ (aborted bus cycle): req is never retracted. Complete the handshake or time out, then go directly to RELEASE without driving.
- DRIVE: bus_doe=1 and bus_dout held. Leave for RELEASE when rd_n=1 or sel=0. bus_doe=0 from the RELEASE entry clk.
- RELEASE: bus_doe=0. Wait for rd_n=1 and wr_n=1, then go to IDLE. bus_dout stays at its last value. A new cycle cannot start until both strobes are high.
- ack outside REQ is ignored.

Optional Feature:
MSX_WAIT_STRETCH_EN
- Defined: wait_n=0 in LATCH and REQ, so the Z80 is stretched until ack or timeout. wait_n returns to 1 the same clk req drops.
- Undefined: wait_n tied to 1, and bus timing relies on ack arriving within the native strobe window.

Decomposition:
- Shared package msx_bus_pkg: state enum (IDLE, LATCH, REQ, DRIVE, RELEASE), the open-bus constant 8'hFF, and the default ADDR_W.
- One sub-module, sample_prescaler: counter plus filt_ena generation, parameterised by PRESCALE.

Test Plan:
- PRESCALE=4 after reset -> filt_ena high exactly every 4th clk. PRESCALE=1 -> filt_ena constant 1.
- Memory read: sltsl_n=0, rd_n=0, addr=16'h4000; ack at the 3rd REQ clk with rdata=8'hA5 -> req_wr=0, req_io=0, req_addr=16'h4000; bus_doe=1 with bus_dout=8'hA5 until rd_n rises, then bus_doe=0.
- I/O write: iorq_n=0, wr_n=0, addr=16'h0098, bus_din=8'h3C -> req_io=1, req_wr=1, req_wdata=8'h3C; bus_doe stays 0 throughout; FSM returns to IDLE after wr_n=1.
- Read with no ack, TIMEOUT_CYC=8 -> req high for 8 clks, one err pulse, bus_dout=8'hFF driven; with the macro defined, wait_n low during LATCH and REQ.
- rd_n and wr_n low together with sltsl_n=0 -> err pulse, req stays 0. Separately, reset_n pulsed low during REQ -> req=0 and bus_doe=0 immediately, state IDLE.
